// File: rtl/router_cfg_seq_pkg.sv
// rtl/router_cfg_seq_pkg.sv - shared state encoding and sizing helper for router_cfg_seq
//
// Purpose : walk-FSM state encoding and the settle-counter width helper.
// Contents: state_t (IDLE, SCAN, ISSUE, SETTLE, DONE), cnt_width().
package router_cfg_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Settle counter width: clog2(SETTLE_CYC+1), kept at least one bit so the
  // counter still exists when the settle gap is zero.
  function automatic int cnt_width(input int settle);
    return (settle < 1) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/router_cfg_seq_if.sv
// rtl/router_cfg_seq_if.sv - staged route request channel for router_cfg_seq
//
// Purpose : groups the route-write handshake between the frontpanel and the sequencer.
// Signals : req_valid_in / req_ready_out handshake, req_dest_in, req_src_in, req_actv_in.
// Modports: master (frontpanel side), slave (sequencer side).
interface router_cfg_seq_if #(
  parameter int W_SEL = 4
);

  logic             req_valid_in;
  logic             req_ready_out;
  logic [W_SEL-1:0] req_dest_in;
  logic [W_SEL-1:0] req_src_in;
  logic             req_actv_in;

  modport master (
    output req_valid_in,
    output req_dest_in,
    output req_src_in,
    output req_actv_in,
    input  req_ready_out
  );

  modport slave (
    input  req_valid_in,
    input  req_dest_in,
    input  req_src_in,
    input  req_actv_in,
    output req_ready_out
  );

endinterface

// File: rtl/router_cfg_seq_prio.sv
// rtl/router_cfg_seq_prio.sv - lowest-set-bit priority encoder used for dirty-entry selection
//
// Purpose : combinational index of the lowest set bit plus an any-set flag.
// Ports   : i_vec (N request bits), o_idx (index of lowest set bit, 0 when none),
//           o_any (at least one bit set).
module prio_enc_lsb #(
  parameter int N     = 8,
  parameter int W_IDX = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_vec,
  output logic [W_IDX-1:0] o_idx,
  output logic             o_any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = W_IDX'(i);
    end
  end

  assign o_any = |i_vec;

endmodule

// File: rtl/router_cfg_seq.sv
// rtl/router_cfg_seq.sv - router configuration sequencer: stages routes, replays dirty entries on commit
//
// Purpose : holds a staged src/activation table per destination and, on commit, replays
//           every dirty entry to the router's single-entry update port with a settle gap.
//           Reset marks every entry dirty so the first walk resynchronises the router.
// Ports   : clk_in, rst_n_in (sync, active low); req_if (slave) staged route writes;
//           commit_in / abort_in walk control; busy_out, done_out, err_out status;
//           src_select_out, dest_select_out, output_active_out, update_out to the router.
module router_cfg_seq
  import router_cfg_seq_pkg::*;
#(
  parameter int               W_SEL      = 4,
  parameter int               N_IN       = 8,
  parameter int               N_OUT      = 8,
  parameter logic [N_OUT-1:0] ACTV_INIT  = {{(N_OUT-1){1'b0}}, 1'b1},
  parameter int               SETTLE_CYC = 2
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  router_cfg_seq_if.slave     req_if,
  input  logic                commit_in,
  input  logic                abort_in,
  output logic                busy_out,
  output logic                done_out,
  output logic                err_out,
  output logic [W_SEL-1:0]    src_select_out,
  output logic [W_SEL-1:0]    dest_select_out,
  output logic [N_OUT-1:0]    output_active_out,
  output logic                update_out
);

  localparam int               W_IDX    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int               W_CNT    = cnt_width(SETTLE_CYC);
  localparam logic [W_SEL:0]   LIM_OUT  = (W_SEL + 1)'(N_OUT);
  localparam logic [W_SEL:0]   LIM_IN   = (W_SEL + 1)'(N_IN);
  localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  state_t             r_state;
  logic [W_SEL-1:0]   r_src [N_OUT];
  logic [N_OUT-1:0]   r_actv;
  logic [N_OUT-1:0]   r_applied;
  logic [N_OUT-1:0]   r_dirty;
  logic [W_CNT-1:0]   r_cnt;
  logic               r_update;
  logic               r_done;
  logic               r_err;
  logic [W_SEL-1:0]   r_src_sel;
  logic [W_SEL-1:0]   r_dest_sel;

  logic [W_IDX-1:0]   w_idx;
  logic               w_any;
  logic               w_req_fire;
  logic               w_req_bad;
  logic [W_IDX-1:0]   w_wr_idx;
  logic               w_step;
  logic               w_go_issue;
  logic               w_go_done;

  prio_enc_lsb #(
    .N     (N_OUT),
    .W_IDX (W_IDX)
  ) u_prio (
    .i_vec (r_dirty),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_req_fire = (r_state == ST_IDLE) && req_if.req_valid_in;
  assign w_req_bad  = ({1'b0, req_if.req_dest_in} >= LIM_OUT) ||
                      ({1'b0, req_if.req_src_in}  >= LIM_IN);
  assign w_wr_idx   = req_if.req_dest_in[W_IDX-1:0];

  // Points where the walk picks its next entry: end of SCAN, end of the settle
  // gap, or straight out of ISSUE when there is no gap. Abort wins over all.
  assign w_step     = !abort_in &&
                      ((r_state == ST_SCAN) ||
                       ((r_state == ST_ISSUE) && (SETTLE_CYC == 0)) ||
                       ((r_state == ST_SETTLE) && (r_cnt == CNT_LAST)));
  assign w_go_issue = w_step && w_any;
  assign w_go_done  = w_step && !w_any;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state    <= ST_IDLE;
      r_actv     <= ACTV_INIT;
      r_applied  <= ACTV_INIT;
      r_dirty    <= '1;
      r_cnt      <= '0;
      r_update   <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_src_sel  <= '0;
      r_dest_sel <= '0;
      for (int i = 0; i < N_OUT; i++) r_src[i] <= '0;
    end else begin
      r_update <= 1'b0;
      r_done   <= 1'b0;

      if (w_go_issue) begin
        // Outputs for the ISSUE cycle are registered on the edge that enters it,
        // and the applied mask only changes for the entry being issued.
        r_state           <= ST_ISSUE;
        r_update          <= 1'b1;
        r_dest_sel        <= W_SEL'(w_idx);
        r_src_sel         <= r_src[w_idx];
        r_applied[w_idx]  <= r_actv[w_idx];
        r_dirty[w_idx]    <= 1'b0;
      end else if (w_go_done) begin
        r_state <= ST_DONE;
        r_done  <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (commit_in) begin
              r_err   <= 1'b0;
              r_state <= ST_SCAN;
            end
            // A request in the commit cycle lands before SCAN samples the dirty set.
            if (w_req_fire) begin
              if (w_req_bad) begin
                r_err <= 1'b1;
              end else begin
                r_src[w_wr_idx]   <= req_if.req_src_in;
                r_actv[w_wr_idx]  <= req_if.req_actv_in;
                r_dirty[w_wr_idx] <= 1'b1;
              end
            end
          end
          ST_SCAN: begin
            r_state <= ST_IDLE;
          end
          ST_ISSUE: begin
            if (abort_in) begin
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_SETTLE;
              r_cnt   <= '0;
            end
          end
          ST_SETTLE: begin
            if (abort_in) r_state <= ST_IDLE;
            else          r_cnt   <= r_cnt + W_CNT'(1);
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign req_if.req_ready_out = (r_state == ST_IDLE);
  assign busy_out             = (r_state != ST_IDLE);
  assign done_out             = r_done;
  assign err_out              = r_err;
  assign src_select_out       = r_src_sel;
  assign dest_select_out      = r_dest_sel;
  assign output_active_out    = r_applied;
  assign update_out           = r_update;

endmodule

// File: tb/tb_router_cfg_seq.sv
// tb/tb_router_cfg_seq.sv - self-checking scoreboard bench for router_cfg_seq
module tb_router_cfg_seq;

  localparam int W_SEL  = 4;
  localparam int N_OUT  = 8;
  localparam int SETTLE = 2;
  localparam int GAP    = SETTLE + 1;

  typedef struct {
    int dest;
    int src;
    int mask;
    int cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             commit;
  logic             abort;
  logic             busy;
  logic             done;
  logic             err;
  logic             update;
  logic [W_SEL-1:0] src_sel;
  logic [W_SEL-1:0] dest_sel;
  logic [N_OUT-1:0] mask;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  int         m_src [N_OUT];
  bit [7:0]   m_actv;
  bit [7:0]   m_applied;
  bit [7:0]   m_dirty;
  bit         m_err;

  always #5 clk = ~clk;

  router_cfg_seq_if #(.W_SEL(W_SEL)) rif ();

  router_cfg_seq #(
    .W_SEL      (W_SEL),
    .N_IN       (8),
    .N_OUT      (N_OUT),
    .ACTV_INIT  (8'h01),
    .SETTLE_CYC (SETTLE)
  ) dut (
    .clk_in            (clk),
    .rst_n_in          (rst_n),
    .req_if            (rif.slave),
    .commit_in         (commit),
    .abort_in          (abort),
    .busy_out          (busy),
    .done_out          (done),
    .err_out           (err),
    .src_select_out    (src_sel),
    .dest_select_out   (dest_sel),
    .output_active_out (mask),
    .update_out        (update)
  );

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_OUT; i++) m_src[i] = 0;
    m_actv    = 8'h01;
    m_applied = 8'h01;
    m_dirty   = 8'hFF;
    m_err     = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_eq({tag, "_update"}, update, 0);
    chk_eq({tag, "_busy"},   busy,   0);
    chk_eq({tag, "_done"},   done,   0);
    chk_eq({tag, "_err"},    err,    0);
    chk_eq({tag, "_src"},    src_sel, 0);
    chk_eq({tag, "_dest"},   dest_sel, 0);
    chk_eq({tag, "_mask"},   mask,   8'h01);
    chk_eq({tag, "_ready"},  rif.req_ready_out, 1);
  endtask

  task automatic do_req(input int dest, input int src, input bit actv);
    chk_eq("req_ready_idle", rif.req_ready_out, 1);
    rif.req_valid_in = 1'b1;
    rif.req_dest_in  = W_SEL'(dest);
    rif.req_src_in   = W_SEL'(src);
    rif.req_actv_in  = actv;
    @(negedge clk);
    rif.req_valid_in = 1'b0;
    if (dest >= N_OUT || src >= 8) begin
      m_err = 1'b1;
    end else begin
      m_src[dest]   = src;
      m_actv[dest]  = actv;
      m_dirty[dest] = 1'b1;
    end
    chk_eq("err_sticky", err, m_err);
  endtask

  // mode 0: full walk; mode 1: abort in the settle gap after n pulses;
  // mode 2: reset during the ISSUE cycle of pulse n+1.
  task automatic do_commit(input int mode, input int n, input bit with_req,
                           input int rd, input int rs, input bit ra);
    exp_t     e;
    int       k = 0;
    int       lim;
    int       done_c;
    int       stop_c;
    int       abort_c;
    bit       seen_done = 1'b0;
    bit [7:0] emask;

    commit = 1'b1;
    if (with_req) begin
      rif.req_valid_in = 1'b1;
      rif.req_dest_in  = W_SEL'(rd);
      rif.req_src_in   = W_SEL'(rs);
      rif.req_actv_in  = ra;
      m_src[rd]   = rs;
      m_actv[rd]  = ra;
      m_dirty[rd] = 1'b1;
    end
    m_err = 1'b0;

    lim   = (mode == 0) ? N_OUT : ((mode == 1) ? n : n + 1);
    emask = m_applied;
    for (int i = 0; i < N_OUT; i++) begin
      if (m_dirty[i] && k < lim) begin
        emask[i]   = m_actv[i];
        e.dest     = i;
        e.src      = m_src[i];
        e.mask     = int'(emask);
        e.cyc      = 2 + k * GAP;
        exp_q.push_back(e);
        m_dirty[i] = 1'b0;
        k++;
      end
    end
    m_applied = emask;
    done_c    = 2 + k * GAP;
    abort_c   = 2 + (n - 1) * GAP + 1;
    stop_c    = (mode == 0) ? done_c + 4 : ((mode == 1) ? abort_c + 5 : 2 + n * GAP + 1);

    for (int c = 1; c <= stop_c; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk_eq("ready_low_walk", rif.req_ready_out, 0);
        chk_eq("busy_walk",      busy, 1);
        chk_eq("err_cleared",    err,  0);
      end
      if (update) begin
        chk_eq("update_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk_eq("upd_dest",  dest_sel, e.dest);
          chk_eq("upd_src",   src_sel,  e.src);
          chk_eq("upd_mask",  mask,     e.mask);
          chk_eq("upd_cycle", c,        e.cyc);
        end
      end
      if (done) begin
        chk_eq("done_cycle", c, done_c);
        seen_done = 1'b1;
      end
      if (mode == 1 && c == abort_c + 1) chk_eq("busy_after_abort", busy, 0);
      if (mode == 2 && c == stop_c) begin
        chk_reset_outputs("rst_mid");
        rst_n = 1'b1;
      end
      commit           = 1'b0;
      rif.req_valid_in = 1'b0;
      abort            = (mode == 1 && c == abort_c);
      if (mode == 2 && c == stop_c - 1) rst_n = 1'b0;
      if (mode == 0 && seen_done) break;
    end
    abort = 1'b0;

    if (mode == 0) chk_eq("done_seen",        seen_done, 1);
    else           chk_eq("no_done_on_cut",   seen_done, 0);
    chk_eq("sb_drained", exp_q.size(), 0);
    exp_q.delete();
    if (mode == 2) model_reset();
    @(negedge clk);
  endtask

  initial begin
    rst_n            = 1'b0;
    commit           = 1'b0;
    abort            = 1'b0;
    rif.req_valid_in = 1'b0;
    rif.req_dest_in  = '0;
    rif.req_src_in   = '0;
    rif.req_actv_in  = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Resync walk after reset: 8 pulses, src 0, mask 0x01, done at 26.
    do_commit(0, 0, 1'b0, 0, 0, 1'b0);

    // Last write wins on dest 3.
    do_req(3, 5, 1'b1);
    do_req(3, 2, 1'b1);
    do_commit(0, 0, 1'b0, 0, 0, 1'b0);

    // Out-of-range dest and src: error only, walk is empty.
    do_req(9, 1, 1'b1);
    do_req(2, 8, 1'b1);
    do_commit(0, 0, 1'b0, 0, 0, 1'b0);
    chk_eq("err_after_commit", err, 0);

    // Abort after dest 1, then finish 4 and 6.
    do_req(1, 7, 1'b1);
    do_req(4, 1, 1'b1);
    do_req(6, 6, 1'b0);
    do_commit(1, 1, 1'b0, 0, 0, 1'b0);
    do_commit(0, 0, 1'b0, 0, 0, 1'b0);

    // Reset during the second ISSUE, then a full resync walk proves dirty=0xFF.
    do_req(2, 3, 1'b1);
    do_req(5, 4, 1'b1);
    do_req(7, 2, 1'b1);
    do_commit(2, 1, 1'b0, 0, 0, 1'b0);
    do_commit(0, 0, 1'b0, 0, 0, 1'b0);

    // Request and commit in the same IDLE cycle.
    do_req(0, 4, 1'b1);
    do_commit(0, 0, 1'b1, 5, 3, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/router_cfg_seq.md
Name: router_cfg_seq

Overview:
Configuration sequencer for the output router. The frontpanel stages route changes as dest/src/active triples. On a commit, the block replays each changed route to the router's single-entry update port, one entry at a time, with a programmable settle gap between updates. After reset it forces a full resynchronisation walk, because the router's select registers have no reset.

Parameters:
W_SEL, 4, width of source/destination select fields
N_IN, 8, number of router input channels (legal src 0..N_IN-1)
N_OUT, 8, number of router output channels (legal dest 0..N_OUT-1)
ACTV_INIT, 1, reset value of the output activation mask (N_OUT bits)
SETTLE_CYC, 2, idle cycles after each update pulse; 0 allowed

Ports:
clk_in  in  1  system clock
rst_n_in  in  1  synchronous active-low reset
req_valid_in  in  1  staged route write request
req_ready_out  out  1  high only in IDLE; request accepted when valid&&ready
req_dest_in  in  W_SEL  destination channel of request
req_src_in  in  W_SEL  source channel of request
req_actv_in  in  1  requested activation for dest
commit_in  in  1  start a walk of all dirty entries (sampled in IDLE only)
abort_in  in  1  stop walk after current update; remaining entries stay dirty
busy_out  out  1  high in every state except IDLE
done_out  out  1  one-cycle pulse when walk completes (not on abort)
err_out  out  1  sticky: out-of-range request seen; cleared on reset or on commit acceptance
src_select_out  out  W_SEL  to router src_select_in
dest_select_out  out  W_SEL  to router dest_select_in
output_active_out  out  N_OUT  to router output_active_in (applied mask)
update_out  out  1  to router update_in; one-cycle pulse per entry

Behaviour:
- One clock: clk_in. Reset is synchronous and active-low (rst_n_in).
- Reset values:
  - staged src table all 0; staged actv = ACTV_INIT.
  - applied mask = ACTV_INIT; dirty = all ones (forces resync).
  - state = IDLE; update_out, done_out, err_out = 0; src/dest outputs = 0.
- Reset mid-walk: abandon immediately; no further update_out; same values as above.
- Request acceptance (IDLE only):
  - valid&&ready writes staged src[dest] and actv[dest], and sets dirty[dest].
  - If dest>=N_OUT or src>=N_IN: request is consumed, table unchanged, err_out set.
  - Repeat writes to the same dest before commit: last write wins.
- commit_in and an accepted request in the same IDLE cycle: the request is written first and is included in the walk.
- States:
  - IDLE: commit -> SCAN; err_out cleared.
  - SCAN (1 cycle): lowest-index dirty entry latched as idx. Any dirty -> ISSUE; none -> DONE.
  - ISSUE (1 cycle):
    - update_out=1; dest_select_out=idx; src_select_out=staged src[idx].
    - output_active_out = applied mask with bit idx replaced by staged actv[idx]; applied mask updates on this edge.
    - dirty[idx] cleared.
    - Next state: SETTLE if SETTLE_CYC>0; else next dirty -> ISSUE, none -> DONE.
  - SETTLE: counts SETTLE_CYC cycles, then next dirty (lowest, combinational) -> ISSUE, none -> DONE.
  - DONE (1 cycle): done_out=1 -> IDLE.
- output_active_out is held at the applied mask in all states, so entries not yet issued keep their old activation (make-before-break per channel).
- Latency: commit sampled at edge 0 with D dirty entries:
  - update pulses at cycles 2+k*(1+SETTLE_CYC), k=0..D-1;
  - done_out at cycle 2+D*(1+SETTLE_CYC); D=0 gives done at cycle 2.
- abort_in sampled in SCAN/SETTLE -> IDLE next cycle. In ISSUE, the pulse completes, then -> IDLE. No done_out on abort; untouched dirty bits remain set.
- commit_in and req_valid_in while busy are ignored (ready low).

Decomposition:
- Shared header: state encodings (IDLE, SCAN, ISSUE, SETTLE, DONE); W_CNT = clog2(SETTLE_CYC+1).
- Sub-module: prio_enc_lsb #(N) — combinational lowest-set-bit index plus any-valid flag; used for dirty selection.

Test Plan:
- Release reset, no requests, SETTLE_CYC=2, commit:
  - 8 update pulses, dest 0..7, src 0, mask 0x01 each;
  - done at cycle 2+8*3=26.
- After resync, write (dest3,src5,actv1) and (dest3,src2,actv1), then commit:
  - single pulse dest3/src2, mask 0x09, at cycle 2; done at cycle 5.
- Write dest=9 (N_OUT=8):
  - err_out=1, no dirty set;
  - commit gives done at cycle 2 with no update, and err_out clears on commit.
- Dirty {1,4,6}, commit, abort in SETTLE after dest1:
  - busy drops next cycle, no done;
  - re-commit issues only 4 and 6.
- Assert rst_n_in during ISSUE of second entry:
  - update_out 0 next cycle, outputs at reset values, dirty=0xFF.
- Request and commit in the same IDLE cycle:
  - request is included in the walk; ready low until done.
